// File: rtl/imem_loader.sv
// Loads a framed program image from a byte stream into instruction memory and holds the core in reset until the checksum matches.
// Write strobe lands one cycle after a word's 4th byte; in_ready stays high through it, so words stream at one byte per cycle.
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t                r_state;
    logic [7:0]            r_len_hi;
    logic [15:0]           r_len;
    logic [15:0]           r_wcnt;
    logic [31:0]           r_word;
    logic [1:0]            r_byte_idx;
    logic [7:0]            r_csum;
    logic [TW-1:0]         r_tmo;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic                  r_core_rst;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [1:0]            r_err_code;
    logic [ADDR_WIDTH:0]   r_words;

    logic        w_accept;
    logic        w_tmo_hit;
    logic [15:0] w_len;
    logic [31:0] w_word;

    assign w_accept  = in_valid && r_busy;
    // An accepted byte in the expiring cycle rescues the load.
    assign w_tmo_hit = !w_accept && (r_tmo == TW'(TIMEOUT - 1));
    assign w_len     = {r_len_hi, in_data};
    assign w_word    = {r_word[23:0], in_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len_hi   <= '0;
            r_len      <= '0;
            r_wcnt     <= '0;
            r_word     <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
            r_tmo      <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_core_rst <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'b00;
            r_words    <= '0;
        end else begin
            r_we <= 1'b0;
            if (r_we) begin
                r_words <= r_words + 1'b1;
                // Saturate so a full-capacity load leaves the address at the top word.
                if (r_addr != '1)
                    r_addr <= r_addr + 1'b1;
            end
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state    <= S_LEN_HI;
                        r_busy     <= 1'b1;
                        r_core_rst <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_err_code <= 2'b00;
                        r_words    <= '0;
                        r_addr     <= '0;
                        r_csum     <= '0;
                        r_tmo      <= '0;
                        r_byte_idx <= '0;
                        r_wcnt     <= '0;
                    end
                end
                default: begin
                    r_tmo <= w_accept ? '0 : r_tmo + 1'b1;
                    if (w_tmo_hit) begin
                        r_state    <= S_ERROR;
                        r_busy     <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= 2'b11;
                    end else if (w_accept) begin
                        case (r_state)
                            S_LEN_HI: begin
                                r_len_hi <= in_data;
                                r_state  <= S_LEN_LO;
                            end
                            S_LEN_LO: begin
                                r_len <= w_len;
                                if ({1'b0, w_len} > CAPACITY) begin
                                    r_state    <= S_ERROR;
                                    r_busy     <= 1'b0;
                                    r_error    <= 1'b1;
                                    r_err_code <= 2'b10;
                                end else if (w_len == 16'd0) begin
                                    r_state <= S_CSUM;
                                end else begin
                                    r_state <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                r_word     <= w_word;
                                r_csum     <= r_csum ^ in_data;
                                r_byte_idx <= r_byte_idx + 1'b1;
                                if (r_byte_idx == 2'd3) begin
                                    r_we    <= 1'b1;
                                    r_wdata <= w_word;
                                    r_wcnt  <= r_wcnt + 1'b1;
                                    if (r_wcnt + 16'd1 == r_len)
                                        r_state <= S_CSUM;
                                end
                            end
                            S_CSUM: begin
                                r_busy <= 1'b0;
                                if (in_data == r_csum) begin
                                    r_state    <= S_DONE;
                                    r_done     <= 1'b1;
                                    r_core_rst <= 1'b0;
                                end else begin
                                    r_state    <= S_ERROR;
                                    r_error    <= 1'b1;
                                    r_err_code <= 2'b01;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign in_ready     = r_busy;
    assign busy         = r_busy;
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign core_rst     = r_core_rst;
    assign done         = r_done;
    assign error        = r_error;
    assign err_code     = r_err_code;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, bad checksum, zero/overflow length, full capacity, timeout, reset mid-load.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [10:0] words_loaded;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int we_count = 0;
    logic [9:0]  last_addr;
    logic [31:0] last_data;

    imem_loader #(.ADDR_WIDTH(10), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .busy(busy), .done(done), .error(error), .err_code(err_code),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            we_count  <= we_count + 1;
            last_addr <= imem_addr;
            last_data <= imem_wdata;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL send_byte: in_ready=%b, required 1 within 50 cycles", in_ready);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
        checks++; if ({imem_we, busy, done, error, err_code} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {imem_we, busy, done, error, err_code}); end
        checks++; if ({imem_addr, imem_wdata, words_loaded} !== 53'd0) begin errors++; $display("FAIL reset_counts: got %h want 0", {imem_addr, imem_wdata, words_loaded}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Frame 00 02 / 20080005 / 8C090004 / checksum (XOR of payload = 0xAC or corrupted)
    task automatic test_nominal(input logic [7:0] csum, input logic expect_ok);
        pulse_start();
        checks++; if ({busy, in_ready, core_rst} !== 3'b111) begin errors++; $display("FAIL start_flags: got %b want 111", {busy, in_ready, core_rst}); end
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd0, 32'h20080005}) begin errors++; $display("FAIL word0_write: got we=%b a=%h d=%h want we=1 a=0 d=20080005", imem_we, imem_addr, imem_wdata); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_in_write: got %b want 1", in_ready); end
        send_byte(8'h8C); send_byte(8'h09); send_byte(8'h00); send_byte(8'h04);
        checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd1, 32'h8C090004}) begin errors++; $display("FAIL word1_write: got we=%b a=%h d=%h want we=1 a=1 d=8C090004", imem_we, imem_addr, imem_wdata); end
        send_byte(csum);
        checks++; if (words_loaded !== 11'd2) begin errors++; $display("FAIL nominal_words: got %0d want 2", words_loaded); end
        checks++; if ({in_ready, busy} !== 2'b00) begin errors++; $display("FAIL end_ready_busy: got %b want 00", {in_ready, busy}); end
        if (expect_ok) begin
            checks++; if ({done, error, core_rst, err_code} !== 5'b10000) begin errors++; $display("FAIL nominal_done: got done/err/crst/code=%b want 10000", {done, error, core_rst, err_code}); end
        end else begin
            checks++; if ({done, error, core_rst, err_code} !== 5'b01101) begin errors++; $display("FAIL bad_csum: got done/err/crst/code=%b want 01101", {done, error, core_rst, err_code}); end
        end
    endtask

    task automatic test_zero_and_overflow();
        int w0;
        w0 = we_count;
        pulse_start();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        @(posedge clk); #1;
        checks++; if ({done, error, core_rst} !== 3'b100) begin errors++; $display("FAIL zero_len_done: got done/err/crst=%b want 100", {done, error, core_rst}); end
        checks++; if (we_count !== w0) begin errors++; $display("FAIL zero_len_writes: got %0d want %0d", we_count, w0); end
        pulse_start();
        send_byte(8'h04); send_byte(8'h01);
        checks++; if ({error, err_code, in_ready, core_rst, done} !== 6'b110010) begin errors++; $display("FAIL overflow: got err/code/rdy/crst/done=%b want 110010", {error, err_code, in_ready, core_rst, done}); end
    endtask

    task automatic test_full_capacity();
        logic [31:0] w;
        logic [7:0]  cs;
        int w0, c0;
        cs = 8'h00;
        w0 = we_count;
        pulse_start();
        send_byte(8'h04); send_byte(8'h00);
        c0 = cyc;
        for (int i = 0; i < 1024; i++) begin
            w = (i * 32'h0001_0001) ^ 32'h5A5A_0000;
            cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
        end
        send_byte(cs);
        checks++; if (cyc - c0 !== 4097) begin errors++; $display("FAIL full_no_bubbles: got %0d cycles want 4097", cyc - c0); end
        @(negedge clk);
        checks++; if (we_count - w0 !== 1024) begin errors++; $display("FAIL full_write_count: got %0d want 1024", we_count - w0); end
        checks++; if (last_addr !== 10'h3FF) begin errors++; $display("FAIL full_last_addr: got %h want 3ff", last_addr); end
        checks++; if (last_data !== ((1023 * 32'h0001_0001) ^ 32'h5A5A_0000)) begin errors++; $display("FAIL full_last_data: got %h", last_data); end
        checks++; if ({words_loaded, done, error} !== {11'd1024, 2'b10}) begin errors++; $display("FAIL full_done: got words=%0d done=%b err=%b want 1024 1 0", words_loaded, done, error); end
    endtask

    // One word DEADBEEF, checksum DE^AD^BE^EF = 22; gap of the given length after byte 2
    task automatic test_stall(input int gap, input logic expect_timeout);
        pulse_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hDE); send_byte(8'hAD);
        repeat (gap) @(posedge clk);
        #1;
        if (expect_timeout) begin
            checks++; if ({error, err_code, in_ready, core_rst} !== 5'b11101) begin errors++; $display("FAIL timeout: got err/code/rdy/crst=%b want 11101", {error, err_code, in_ready, core_rst}); end
        end else begin
            checks++; if ({error, busy} !== 2'b01) begin errors++; $display("FAIL stall_no_error: got err/busy=%b want 01", {error, busy}); end
            send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h22);
            checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL stall_done: got done/err=%b want 10", {done, error}); end
        end
    endtask

    task automatic test_reset_restart();
        int w0;
        pulse_start();
        send_byte(8'h00); send_byte(8'h04);
        for (int i = 0; i < 15; i++) send_byte(8'h10 + 8'(i));
        w0 = we_count;
        in_data = 8'hFF; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        checks++; if ({imem_we, in_ready, busy, done, error, err_code, core_rst} !== 8'b00000001) begin errors++; $display("FAIL rst_mid_flags: got %b want 00000001", {imem_we, in_ready, busy, done, error, err_code, core_rst}); end
        checks++; if ({imem_addr, imem_wdata, words_loaded} !== 53'd0) begin errors++; $display("FAIL rst_mid_counts: got %h want 0", {imem_addr, imem_wdata, words_loaded}); end
        @(posedge clk); #1;
        checks++; if (we_count !== w0) begin errors++; $display("FAIL rst_dropped_write: got %0d writes want %0d", we_count, w0); end
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        checks++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd0, 32'hDEADBEEF}) begin errors++; $display("FAIL restart_write: got we=%b a=%h d=%h want 1 0 deadbeef", imem_we, imem_addr, imem_wdata); end
        send_byte(8'h22);
        checks++; if ({done, core_rst, words_loaded} !== {2'b10, 11'd1}) begin errors++; $display("FAIL restart_done: got done=%b crst=%b words=%0d want 1 0 1", done, core_rst, words_loaded); end
    endtask

    initial begin
        test_reset();
        test_nominal(8'h20 ^ 8'h08 ^ 8'h00 ^ 8'h05 ^ 8'h8C ^ 8'h09 ^ 8'h00 ^ 8'h04, 1'b1);
        test_nominal(8'h00, 1'b0);
        test_zero_and_overflow();
        test_full_capacity();
        test_stall(15, 1'b0);
        test_stall(16, 1'b1);
        test_reset_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
